// File: rtl/core_pkg.sv
// Shared types for the core-bus arbiter.
// Requester indices, selection states and small helpers.
package core_pkg;

   typedef enum logic {
      REQ_INSTR = 1'b0,
      REQ_DATA  = 1'b1
   } req_idx_e;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   localparam int NUM_REQ = 2;

   function automatic req_idx_e other_req(input req_idx_e r);
      return (r == REQ_INSTR) ? REQ_DATA : REQ_INSTR;
   endfunction

endpackage

// File: rtl/core_arbiter_owner_fifo.sv
// Small FIFO recording which requester owns each outstanding transaction.
// Depth is a power of two; pointers wrap modulo DEPTH.
module owner_fifo #(
   parameter  int DEPTH = 2,
   parameter  int W     = 1,
   localparam int CW    = $clog2(DEPTH) + 1,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          aclk,
   input  logic          areset,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic [CW-1:0] cnt,
   output logic          full,
   output logic          empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && !full;
   assign head    = mem[rd_ptr];

   // Storage: owner index written at the tail on every accepted push.
   always_ff @(posedge aclk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // Pointers and occupancy; simultaneous push and pop keep cnt.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= nxt(wr_ptr);
         if (pop_ok)  rd_ptr <= nxt(rd_ptr);
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/core_arbiter.sv
// Two-port core-bus arbiter (instruction/data) toward a single bridge.
// Round-robin selection, stall lock, and in-order response routing.
module core_arbiter
   import core_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MAX_OUT = 2
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic [1:0]               s_req,
   input  logic [1:0]               s_we,
   input  logic [1:0][ADDR_W-1:0]   s_addr,
   input  logic [1:0][DATA_W/8-1:0] s_be,
   input  logic [1:0][DATA_W-1:0]   s_wdata,
   output logic [1:0]               s_gnt,
   output logic [1:0]               s_rvalid,
   output logic [1:0]               s_err,
   output logic [DATA_W-1:0]        s_rdata,
   output logic                     m_req,
   output logic                     m_we,
   output logic [ADDR_W-1:0]        m_addr,
   output logic [DATA_W/8-1:0]      m_be,
   output logic [DATA_W-1:0]        m_wdata,
   input  logic                     m_gnt,
   input  logic                     m_rvalid,
   input  logic                     m_err,
   input  logic [DATA_W-1:0]        m_rdata,
   output logic                     resp_orphan
);

   localparam int CNT_W = $clog2(MAX_OUT) + 1;

   arb_state_e state_q, state_d;
   req_idx_e   sel_q, sel_d;
   req_idx_e   rr_q, rr_d;
   req_idx_e   win;
   logic       win_i;
   logic       act;
   logic       accept;
   logic       pop;
   logic       head;
   logic       f_full;
   logic       f_empty;
   logic [CNT_W-1:0] f_cnt;

   assign win_i   = win;
   assign s_rdata = m_rdata;

   // Winner: held selection when locked, else round-robin on requests.
   always_comb begin
      win = REQ_INSTR;
      if (state_q == LOCKED)     win = sel_q;
      else if (&s_req)           win = rr_q;
      else if (s_req[REQ_DATA])  win = REQ_DATA;
      else                       win = REQ_INSTR;
   end

   // Forward the winner's command; gating uses only registered cnt.
   always_comb begin
      act     = (state_q == LOCKED) ? s_req[sel_q] : |s_req;
      m_req   = act && !f_full;
      m_we    = s_we[win_i];
      m_addr  = s_addr[win_i];
      m_be    = s_be[win_i];
      m_wdata = s_wdata[win_i];
      accept  = m_req && m_gnt;
   end

   // Next selection state: lock on stall, release and rotate on grant.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      rr_d    = rr_q;
      if (accept) begin
         state_d = IDLE;
         rr_d    = other_req(win);
      end else if (m_req) begin
         state_d = LOCKED;
         sel_d   = win;
      end else if (state_q == LOCKED && !s_req[sel_q]) begin
         state_d = IDLE;
      end
   end

   // Selection state registers.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q <= IDLE;
         sel_q   <= REQ_INSTR;
         rr_q    <= REQ_INSTR;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         rr_q    <= rr_d;
      end
   end

   // Grant and response routing to the requesters.
   always_comb begin
      pop      = m_rvalid && !f_empty;
      s_gnt    = '0;
      s_rvalid = '0;
      s_err    = '0;
      if (accept) s_gnt[win_i] = 1'b1;
      if (pop) begin
         s_rvalid[head] = 1'b1;
         s_err[head]    = m_err;
      end
   end

   // Sticky flag for responses with nothing outstanding.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset)                       resp_orphan <= 1'b0;
      else if (m_rvalid && f_cnt == '0) resp_orphan <= 1'b1;
   end

   owner_fifo #(
      .DEPTH (MAX_OUT),
      .W     (1)
   ) u_owner (
      .aclk   (aclk),
      .areset (areset),
      .push   (accept),
      .din    (win_i),
      .pop    (pop),
      .head   (head),
      .cnt    (f_cnt),
      .full   (f_full),
      .empty  (f_empty)
   );

endmodule

// File: tb/tb_core_arbiter.sv
// Directed bench for core_arbiter with hand-computed expectations.
// Inputs change just after each rising edge; outputs checked 1ns later.
module tb_core_arbiter;

   logic              aclk = 1'b0;
   logic              areset;
   logic [1:0]        s_req, s_we;
   logic [1:0][31:0]  s_addr;
   logic [1:0][3:0]   s_be;
   logic [1:0][31:0]  s_wdata;
   logic [1:0]        s_gnt, s_rvalid, s_err;
   logic [31:0]       s_rdata;
   logic              m_req, m_we;
   logic [31:0]       m_addr;
   logic [3:0]        m_be;
   logic [31:0]       m_wdata;
   logic              m_gnt, m_rvalid, m_err;
   logic [31:0]       m_rdata;
   logic              resp_orphan;

   int vec  = 0;
   int miss = 0;

   always #5 aclk = ~aclk;

   core_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(2)) dut (
      .aclk        (aclk),
      .areset      (areset),
      .s_req       (s_req),
      .s_we        (s_we),
      .s_addr      (s_addr),
      .s_be        (s_be),
      .s_wdata     (s_wdata),
      .s_gnt       (s_gnt),
      .s_rvalid    (s_rvalid),
      .s_err       (s_err),
      .s_rdata     (s_rdata),
      .m_req       (m_req),
      .m_we        (m_we),
      .m_addr      (m_addr),
      .m_be        (m_be),
      .m_wdata     (m_wdata),
      .m_gnt       (m_gnt),
      .m_rvalid    (m_rvalid),
      .m_err       (m_err),
      .m_rdata     (m_rdata),
      .resp_orphan (resp_orphan)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge aclk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      areset   = 1'b1;
      s_req    = '0;
      s_we     = '0;
      s_addr   = '0;
      s_be     = '0;
      s_wdata  = '0;
      m_gnt    = 1'b0;
      m_rvalid = 1'b0;
      m_err    = 1'b0;
      m_rdata  = '0;
      #2;
      check("rst_m_req", m_req, 0);
      check("rst_s_gnt", s_gnt, 0);
      check("rst_s_rvalid", s_rvalid, 0);
      check("rst_s_err", s_err, 0);
      check("rst_orphan", resp_orphan, 0);
      cyc();
      cyc();
      areset = 1'b0;
      settle();
      check("post_rst_m_req", m_req, 0);

      // Round-robin with zero-wait grant, response one cycle later.
      cyc();
      s_addr[0] = 32'h10;
      s_addr[1] = 32'h20;
      s_be[0]   = 4'h3;
      s_be[1]   = 4'hC;
      s_req     = 2'b11;
      m_gnt     = 1'b1;
      settle();
      check("rr_a_gnt", s_gnt, 2'b01);
      check("rr_a_addr", m_addr, 32'h10);
      check("rr_a_be", m_be, 4'h3);
      check("rr_a_rv", s_rvalid, 2'b00);
      cyc();
      m_rvalid = 1'b1;
      m_rdata  = 32'hA0;
      settle();
      check("rr_b_gnt", s_gnt, 2'b10);
      check("rr_b_addr", m_addr, 32'h20);
      check("rr_b_rv", s_rvalid, 2'b01);
      check("rr_b_rdata", s_rdata, 32'hA0);
      cyc();
      m_rdata = 32'hA1;
      settle();
      check("rr_c_gnt", s_gnt, 2'b01);
      check("rr_c_rv", s_rvalid, 2'b10);
      cyc();
      settle();
      check("rr_d_gnt", s_gnt, 2'b10);
      check("rr_d_rv_head", s_rvalid, 2'b01);
      cyc();
      s_req = 2'b00;
      m_gnt = 1'b0;
      settle();
      check("rr_e_m_req", m_req, 0);
      check("rr_e_rv", s_rvalid, 2'b10);

      // Stall lock: data port held stable while instruction port arrives.
      cyc();
      m_rvalid  = 1'b0;
      s_req     = 2'b10;
      s_we      = 2'b10;
      s_addr[1] = 32'h100;
      s_addr[0] = 32'h200;
      settle();
      check("lk1_m_req", m_req, 1);
      check("lk1_gnt", s_gnt, 2'b00);
      check("lk1_addr", m_addr, 32'h100);
      cyc();
      s_req = 2'b11;
      settle();
      check("lk2_addr", m_addr, 32'h100);
      check("lk2_we", m_we, 1);
      cyc();
      settle();
      check("lk3_addr", m_addr, 32'h100);
      check("lk3_gnt", s_gnt, 2'b00);
      cyc();
      m_gnt = 1'b1;
      settle();
      check("lk4_gnt", s_gnt, 2'b10);
      check("lk4_addr", m_addr, 32'h100);
      cyc();
      s_req = 2'b01;
      settle();
      check("lk5_gnt", s_gnt, 2'b01);
      check("lk5_addr", m_addr, 32'h200);
      check("lk5_we", m_we, 0);

      // Error response to head owner (data port), then instruction port.
      cyc();
      s_req    = 2'b00;
      m_gnt    = 1'b0;
      m_rvalid = 1'b1;
      m_err    = 1'b1;
      m_rdata  = 32'hDEADBEEF;
      settle();
      check("err_rv", s_rvalid, 2'b10);
      check("err_err", s_err, 2'b10);
      check("err_rdata", s_rdata, 32'hDEADBEEF);
      cyc();
      m_err = 1'b0;
      settle();
      check("err2_rv", s_rvalid, 2'b01);
      check("err2_err", s_err, 2'b00);

      // Outstanding limit: third request waits, no rvalid bypass.
      cyc();
      m_rvalid = 1'b0;
      s_req    = 2'b01;
      m_gnt    = 1'b1;
      settle();
      check("lim1_gnt", s_gnt, 2'b01);
      cyc();
      settle();
      check("lim2_gnt", s_gnt, 2'b01);
      cyc();
      settle();
      check("lim3_m_req", m_req, 0);
      check("lim3_gnt", s_gnt, 2'b00);
      cyc();
      m_rvalid = 1'b1;
      settle();
      check("lim4_m_req", m_req, 0);
      check("lim4_rv", s_rvalid, 2'b01);
      cyc();
      m_rvalid = 1'b0;
      settle();
      check("lim5_m_req", m_req, 1);
      check("lim5_gnt", s_gnt, 2'b01);
      cyc();
      s_req    = 2'b00;
      m_rvalid = 1'b1;
      settle();
      check("lim6_rv", s_rvalid, 2'b01);
      cyc();
      settle();
      check("lim7_rv", s_rvalid, 2'b01);

      // Orphan response with nothing outstanding.
      cyc();
      settle();
      check("orph_rv", s_rvalid, 2'b00);
      check("orph_flag_pre", resp_orphan, 0);
      cyc();
      m_rvalid = 1'b0;
      settle();
      check("orph_flag", resp_orphan, 1);
      cyc();
      settle();
      check("orph_sticky", resp_orphan, 1);
      cyc();
      areset = 1'b1;
      settle();
      check("orph_rst_clr", resp_orphan, 0);
      cyc();
      areset = 1'b0;

      // Reset mid-transaction discards ownership.
      cyc();
      s_req = 2'b01;
      m_gnt = 1'b1;
      settle();
      check("mid_gnt", s_gnt, 2'b01);
      cyc();
      s_req  = 2'b00;
      m_gnt  = 1'b0;
      areset = 1'b1;
      settle();
      check("mid_rst_m_req", m_req, 0);
      check("mid_rst_rv", s_rvalid, 2'b00);
      cyc();
      areset   = 1'b0;
      m_rvalid = 1'b1;
      settle();
      check("mid_rv_drop", s_rvalid, 2'b00);
      check("mid_err_drop", s_err, 2'b00);
      cyc();
      m_rvalid = 1'b0;
      settle();
      check("mid_orphan", resp_orphan, 1);

      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule

// File: doc/core_arbiter.md
CORE_ARBITER -- requirements
Module: core_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data width; byte-enable width is DATA_W/8.
REQ-003 Parameter MAX_OUT, default 2, maximum outstanding downstream transactions; power of two, at least 1.
REQ-004 aclk  input  1  the only clock; all state updates on rising edge.
REQ-005 areset  input  1  asynchronous, active-high reset.
REQ-006 s_req, s_we  input  [1:0]  per-requester request and write-enable; index 0 = instruction port, index 1 = data port.
REQ-007 s_addr  input  [1:0][ADDR_W-1:0], s_be  input  [1:0][DATA_W/8-1:0], s_wdata  input  [1:0][DATA_W-1:0]  per-requester command fields.
REQ-008 s_gnt, s_rvalid, s_err  output  [1:0]  per-requester grant, response-valid and response-error.
REQ-009 s_rdata  output  DATA_W  response data, shared by both requesters.
REQ-010 m_req, m_we  output  1, m_addr  output  ADDR_W, m_be  output  DATA_W/8, m_wdata  output  DATA_W  downstream command toward the core-bus-to-AXI4-Lite bridge.
REQ-011 m_gnt, m_rvalid, m_err  input  1, m_rdata  input  DATA_W  downstream grant and response.
REQ-012 resp_orphan  output  1  sticky flag: a response arrived with no transaction outstanding.

Function
REQ-013 Selection state SHALL be IDLE or LOCKED.
- IDLE: selection is combinational.
- LOCKED: selection is held in register sel.
REQ-014 In IDLE, arbitration SHALL be round-robin between asserted s_req bits.
- Pointer rr names the preferred requester.
- A single requester wins regardless of rr.
REQ-015 Forwarding gate:
- m_req SHALL equal the winner's s_req, gated off when cnt == MAX_OUT.
- m_we, m_addr, m_be and m_wdata SHALL be muxed from the winner.
REQ-016 Lock:
- m_req=1 with m_gnt=0 -> LOCKED, sel = winner.
- While LOCKED, m_req and all command fields SHALL come from sel, giving core-bus stability.
- m_gnt=1 in the same cycle -> no lock; grant is zero-wait.
REQ-017 s_gnt[sel] SHALL equal m_gnt AND m_req, combinationally; the other s_gnt bit SHALL be 0.
REQ-018 On an accepted grant (m_req AND m_gnt):
- push the winner index into the owner FIFO (depth MAX_OUT);
- set rr to the other requester;
- return to IDLE.
REQ-019 On m_rvalid with cnt > 0:
- s_rvalid[head] = 1 and s_err[head] = m_err, same cycle;
- pop the owner FIFO.
- s_rdata SHALL equal m_rdata at all times.
REQ-020 Push and pop in the same cycle SHALL leave cnt unchanged. Pointers wrap modulo MAX_OUT.
REQ-021 When cnt == MAX_OUT and m_rvalid=1, new forwarding SHALL still wait one cycle; there is no rvalid-to-req bypass.
REQ-022 m_rvalid with cnt == 0 SHALL be dropped: no s_rvalid, and resp_orphan set until reset.
REQ-023 cnt SHALL be log2(MAX_OUT)+1 bits wide and SHALL never exceed MAX_OUT or underflow.

Reset
REQ-024 areset SHALL asynchronously force:
- state=IDLE, rr=0, sel=0, cnt=0, FIFO pointers=0, resp_orphan=0.
REQ-025 During and after reset, until a new request arrives, m_req, s_gnt, s_rvalid and s_err SHALL be 0.
REQ-026 Reset mid-transaction SHALL discard all outstanding ownership. A subsequent m_rvalid is then treated per REQ-022.

Structure
REQ-027 Shared package core_pkg SHALL hold:
- the requester-index typedef (REQ_INSTR=0, REQ_DATA=1);
- the state enum (IDLE=0, LOCKED=1).
REQ-028 The owner FIFO SHALL be a sub-module, owner_fifo, parameterised by depth and entry width, with push, pop, head, cnt, full and empty.
REQ-029 The arbiter SHALL contain no combinational path from m_rvalid to m_req.

Verification
REQ-030 Both s_req=1 from reset, m_gnt=1 always, m_rvalid one cycle after each grant:
- grants alternate 0,1,0,1;
- responses route to the same order.
REQ-031 s_req[1]=1, addr 0x100, we=1; m_gnt held 0 for 3 cycles while s_req[0] rises:
- m_addr stays 0x100 and m_we stays 1;
- s_gnt[1] fires in cycle 4;
- s_req[0] is granted next.
REQ-032 MAX_OUT=2, m_rvalid held 0, 3 requests from port 0:
- 2 grants, then m_req=0 with cnt=2;
- one m_rvalid -> third grant the cycle after.
REQ-033 Push and pop in the same cycle with cnt=1:
- cnt stays 1;
- s_rvalid goes to the FIFO head, not the new grant.
REQ-034 m_rvalid=1, m_err=1 with owner head=1 -> s_rvalid=2'b10, s_err=2'b10, s_rdata=m_rdata.
REQ-035 m_rvalid pulse with cnt=0, or right after areset pulsed mid-transaction:
- no s_rvalid;
- resp_orphan=1 until the next areset.
